// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline package: data-memory geometry, writeback register layout and bubble constants.
// Imported by every pipe stage that needs the common defaults.
package mem_wb_stage_pkg;

    localparam int DM_DEPTH_DEF = 64;
    localparam int DM_AW_DEF    = 6;

    localparam logic BUBBLE_RFWE  = 1'b0;
    localparam logic BUBBLE_MTORF = 1'b0;

    typedef struct packed {
        logic        rfwe;
        logic        mtorf;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  rt;
    } wb_regs_t;

    localparam wb_regs_t WB_BUBBLE = '{
        rfwe:  BUBBLE_RFWE,
        mtorf: BUBBLE_MTORF,
        alu:   32'd0,
        rd:    32'd0,
        rt:    5'd0
    };

    // Only word-aligned accesses are legal; non-memory instructions never flag.
    function automatic logic is_misaligned(input logic [1:0] lsb, input logic dmwe, input logic mtorf);
        return (lsb != 2'b00) && (dmwe || mtorf);
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Word-organised data memory: one synchronous write port, one asynchronous read port.
// Reads return the pre-edge contents, so a same-edge write is visible only to later reads.
module data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH_DEF,
    parameter int AW    = DM_AW_DEF
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] ram [DEPTH];

    // NOTE: the array has no reset; clearing it would force a flop-based RAM and contents are undefined until written.
    always_ff @(posedge CLK) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-memory access, misalignment detection and writeback registers.
// Flush loads a bubble and beats stall; reset beats both and drops any pending store.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DM_DEPTH = DM_DEPTH_DEF,
    parameter int DM_AW    = DM_AW_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RFWEM,
    input  logic        DMWEM,
    input  logic        MtoRFselM,
    input  logic [31:0] ALU_outM,
    input  logic [31:0] DMinM,
    input  logic [4:0]  RtDM,
    input  logic        StallW,
    input  logic        FlushW,
    output logic        RFWEW,
    output logic        MtoRFselW,
    output logic [31:0] ALU_outW,
    output logic [31:0] RDW,
    output logic [4:0]  RtDW,
    output logic [31:0] ResultW,
    output logic        MisalignM
);

    wb_regs_t         wb_q;
    wb_regs_t         wb_d;
    logic [DM_AW-1:0] dm_idx;
    logic [31:0]      dm_rdata;
    logic             dm_we;
    logic             load_misalign;

    // Upper address bits are dropped, so the memory aliases every 4*DM_DEPTH bytes.
    assign dm_idx        = ALU_outM[DM_AW+1:2];
    assign MisalignM     = is_misaligned(ALU_outM[1:0], DMWEM, MtoRFselM);
    assign load_misalign = MisalignM & MtoRFselM;
    assign dm_we         = DMWEM & ~MisalignM & ~StallW & ~FlushW & ~RST;

    data_mem #(
        .DEPTH (DM_DEPTH),
        .AW    (DM_AW)
    ) u_data_mem (
        .CLK   (CLK),
        .we    (dm_we),
        .addr  (dm_idx),
        .wdata (DMinM),
        .rdata (dm_rdata)
    );

    // NOTE: every field of wb_d is assigned on every pass, so no latch can be inferred.
    always_comb begin
        wb_d       = WB_BUBBLE;
        wb_d.rfwe  = RFWEM & ~load_misalign;
        wb_d.mtorf = MtoRFselM;
        wb_d.alu   = ALU_outM;
        wb_d.rd    = load_misalign ? 32'd0 : dm_rdata;
        wb_d.rt    = RtDM;
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_q <= WB_BUBBLE;
        end else if (FlushW) begin
            wb_q <= WB_BUBBLE;
        end else if (!StallW) begin
            wb_q <= wb_d;
        end
    end

    assign RFWEW     = wb_q.rfwe;
    assign MtoRFselW = wb_q.mtorf;
    assign ALU_outW  = wb_q.alu;
    assign RDW       = wb_q.rd;
    assign RtDW      = wb_q.rt;
    assign ResultW   = wb_q.mtorf ? wb_q.rd : wb_q.alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared against a word-array reference model of the stage.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RFWEM, DMWEM, MtoRFselM;
    logic [31:0] ALU_outM, DMinM;
    logic [4:0]  RtDM;
    logic        StallW, FlushW;
    logic        RFWEW, MtoRFselW;
    logic [31:0] ALU_outW, RDW, ResultW;
    logic [4:0]  RtDW;
    logic        MisalignM;

    int total = 0;
    int bad   = 0;

    // Reference model: memory as a plain word array, expected W-stage values.
    logic [31:0] mem_m [64];
    logic        e_rfwe, e_mtorf;
    logic [31:0] e_alu, e_rd;
    logic [4:0]  e_rt;

    mem_wb_stage dut (
        .CLK       (CLK),
        .RST       (RST),
        .RFWEM     (RFWEM),
        .DMWEM     (DMWEM),
        .MtoRFselM (MtoRFselM),
        .ALU_outM  (ALU_outM),
        .DMinM     (DMinM),
        .RtDM      (RtDM),
        .StallW    (StallW),
        .FlushW    (FlushW),
        .RFWEW     (RFWEW),
        .MtoRFselW (MtoRFselW),
        .ALU_outW  (ALU_outW),
        .RDW       (RDW),
        .RtDW      (RtDW),
        .ResultW   (ResultW),
        .MisalignM (MisalignM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] e_result();
        return e_mtorf ? e_rd : e_alu;
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic w, input logic l);
        return ((a % 4) != 0) && (w || l);
    endfunction

    // Present one M-stage instruction; settles combinational outputs before returning.
    task automatic drive(input logic rf, input logic we, input logic ld, input logic [31:0] addr,
                         input logic [31:0] din, input logic [4:0] rt,
                         input logic st, input logic fl, input logic rs);
        RFWEM = rf; DMWEM = we; MtoRFselM = ld; ALU_outM = addr; DMinM = din;
        RtDM = rt; StallW = st; FlushW = fl; RST = rs;
        #1;
    endtask

    // Advance the model and the DUT by one clock; no checking here.
    task automatic step();
        int          idx;
        logic        mis;
        logic [31:0] rd_now;
        idx    = int'((ALU_outM % 256) / 4);
        mis    = model_mis(ALU_outM, DMWEM, MtoRFselM);
        rd_now = mem_m[idx];
        if (RST || FlushW) begin
            e_rfwe = 0; e_mtorf = 0; e_alu = 0; e_rd = 0; e_rt = 0;
        end else if (!StallW) begin
            e_rfwe  = RFWEM && !(mis && MtoRFselM);
            e_mtorf = MtoRFselM;
            e_alu   = ALU_outM;
            e_rd    = (mis && MtoRFselM) ? 32'd0 : rd_now;
            e_rt    = RtDM;
            if (DMWEM && !mis) mem_m[idx] = DMinM;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 32'h8, 32'h1, 5'd9, 0, 0, 1);
        step();
        total++;
        if ({RFWEW, MtoRFselW, ALU_outW, RDW, RtDW, ResultW} !== '0) begin
            bad++;
            $display("FAIL reset: got rfwe=%b mtorf=%b alu=%h rd=%h rt=%0d res=%h, want all 0",
                     RFWEW, MtoRFselW, ALU_outW, RDW, RtDW, ResultW);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 64; i++) begin
            drive(0, 1, 0, 32'(i * 4), $urandom, 5'd0, 0, 0, 0);
            step();
        end
    endtask

    task automatic test_store_load();
        drive(0, 1, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0);
        step();
        drive(1, 0, 1, 32'h10, 32'h0, 5'd3, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'hDEADBEEF || ResultW !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL store_load: got rd=%h res=%h, want deadbeef", RDW, ResultW);
        end
        total++;
        if (RFWEW !== 1'b1 || RtDW !== 5'd3 || MtoRFselW !== 1'b1) begin
            bad++;
            $display("FAIL store_load_ctl: got rfwe=%b rt=%0d mtorf=%b, want 1 3 1", RFWEW, RtDW, MtoRFselW);
        end
    endtask

    task automatic test_misaligned_store();
        drive(0, 1, 0, 32'h13, 32'h1234, 5'd0, 0, 0, 0);
        total++;
        if (MisalignM !== 1'b1) begin
            bad++;
            $display("FAIL mis_store_flag: got %b, want 1", MisalignM);
        end
        step();
        total++;
        if (ALU_outW !== 32'h13) begin
            bad++;
            $display("FAIL mis_store_advance: got alu=%h, want 13", ALU_outW);
        end
        drive(1, 0, 1, 32'h10, 32'h0, 5'd4, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL mis_store_mem: got rd=%h, want deadbeef", RDW);
        end
    endtask

    task automatic test_misaligned_load();
        drive(1, 0, 1, 32'h22, 32'h0, 5'd6, 0, 0, 0);
        total++;
        if (MisalignM !== 1'b1) begin
            bad++;
            $display("FAIL mis_load_flag: got %b, want 1", MisalignM);
        end
        step();
        total++;
        if (RFWEW !== 1'b0 || RDW !== 32'd0 || ResultW !== 32'd0) begin
            bad++;
            $display("FAIL mis_load: got rfwe=%b rd=%h res=%h, want 0 0 0", RFWEW, RDW, ResultW);
        end
        drive(1, 0, 0, 32'h23, 32'h0, 5'd6, 0, 0, 0);
        total++;
        if (MisalignM !== 1'b0) begin
            bad++;
            $display("FAIL mis_alu_only: got %b, want 0", MisalignM);
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 32'h777, 32'h0, 5'd5, 0, 0, 0);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 32'h40, 32'h55, 5'd1, 1, 0, 0);
            step();
            total++;
            if (RFWEW !== 1'b1 || ALU_outW !== 32'h777 || RtDW !== 5'd5 || MtoRFselW !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got rfwe=%b alu=%h rt=%0d, want 1 777 5", c, RFWEW, ALU_outW, RtDW);
            end
        end
        drive(0, 1, 0, 32'h40, 32'h55, 5'd1, 0, 0, 0);
        step();
        drive(1, 0, 1, 32'h40, 32'h0, 5'd2, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'h55) begin
            bad++;
            $display("FAIL stall_release: got rd=%h, want 55", RDW);
        end
        drive(0, 1, 0, 32'h40, 32'h77, 5'd0, 1, 0, 0);
        step();
        drive(1, 0, 1, 32'h40, 32'h0, 5'd2, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'h55) begin
            bad++;
            $display("FAIL stall_no_write: got rd=%h, want 55", RDW);
        end
    endtask

    task automatic test_flush_over_stall();
        drive(1, 1, 0, 32'h40, 32'hEE, 5'd7, 1, 1, 0);
        step();
        total++;
        if (RFWEW !== 1'b0 || RtDW !== 5'd0 || ALU_outW !== 32'd0 || RDW !== 32'd0 || ResultW !== 32'd0) begin
            bad++;
            $display("FAIL flush: got rfwe=%b rt=%0d alu=%h rd=%h, want bubble", RFWEW, RtDW, ALU_outW, RDW);
        end
        drive(1, 0, 1, 32'h40, 32'h0, 5'd2, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'h55) begin
            bad++;
            $display("FAIL flush_no_write: got rd=%h, want 55", RDW);
        end
    endtask

    task automatic test_wrap_reset();
        drive(0, 1, 0, 32'h100, 32'hA5, 5'd0, 0, 0, 0);
        step();
        drive(1, 0, 1, 32'h000, 32'h0, 5'd8, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'hA5 || ResultW !== 32'hA5) begin
            bad++;
            $display("FAIL wrap: got rd=%h res=%h, want a5", RDW, ResultW);
        end
        drive(1, 1, 0, 32'h000, 32'h77, 5'd9, 0, 0, 1);
        step();
        total++;
        if ({RFWEW, MtoRFselW, ALU_outW, RDW, RtDW, ResultW} !== '0) begin
            bad++;
            $display("FAIL reset_pending: got rfwe=%b alu=%h rd=%h rt=%0d, want all 0", RFWEW, ALU_outW, RDW, RtDW);
        end
        drive(1, 0, 1, 32'h000, 32'h0, 5'd8, 0, 0, 0);
        step();
        total++;
        if (RDW !== 32'hA5) begin
            bad++;
            $display("FAIL reset_drop: got rd=%h, want a5", RDW);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
                  $urandom, 5'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
            total++;
            if (MisalignM !== model_mis(ALU_outM, DMWEM, MtoRFselM)) begin
                bad++;
                $display("FAIL rnd_mis[%0d]: got %b, want %b", n, MisalignM, model_mis(ALU_outM, DMWEM, MtoRFselM));
            end
            step();
            total++;
            if (RFWEW !== e_rfwe || MtoRFselW !== e_mtorf || ALU_outW !== e_alu ||
                RDW !== e_rd || RtDW !== e_rt || ResultW !== e_result()) begin
                bad++;
                $display("FAIL rnd_wb[%0d]: got %b %b %h %h %0d %h, want %b %b %h %h %0d %h", n,
                         RFWEW, MtoRFselW, ALU_outW, RDW, RtDW, ResultW,
                         e_rfwe, e_mtorf, e_alu, e_rd, e_rt, e_result());
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
        @(posedge CLK);
        #1;
        test_reset();
        init_mem();
        test_store_load();
        test_misaligned_store();
        test_misaligned_load();
        test_stall();
        test_flush_over_stall();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
